// File: rtl/count_capture.sv
// ---------------------------------------------------------------------------
// count_capture
//
// Input-capture stage that sits behind a free-running up counter. The
// asynchronous event line is synchronised, the selected edge type is
// detected, and the counter value present on each event is queued in a small
// first-word-fall-through FIFO that a valid/ready consumer drains. Captures
// that arrive while the FIFO is full (and not being popped) are dropped and
// flagged in a sticky overflow bit.
//
// Optional feature, enabled by defining COUNT_CAPTURE_EPOCH_EN:
//   an epoch counter tracks counter wraps (previous count > current count),
//   every FIFO entry carries {epoch, count}, and the head epoch appears on
//   cap_epoch. Adds parameter EPOCH_W.
//
// Ports:
//   clk           sole clock, rising edge
//   clear         synchronous active-high reset
//   count         upstream counter value, synchronous to clk
//   event_in      asynchronous event line
//   edge_sel      00 disabled, 01 rising, 10 falling, 11 both
//   cap_valid     FIFO head valid
//   cap_ready     consumer accepts head
//   cap_data      FIFO head count value (0 when empty)
//   cap_epoch     FIFO head epoch (COUNT_CAPTURE_EPOCH_EN only)
//   fifo_level    number of entries held, 0..DEPTH
//   overflow      sticky: a capture was dropped
//   overflow_clr  clears overflow (a coincident new drop wins)
// ---------------------------------------------------------------------------
module count_capture #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
`ifdef COUNT_CAPTURE_EPOCH_EN
  parameter int SYNC_STAGES = 2,
  parameter int EPOCH_W     = 4
`else
  parameter int SYNC_STAGES = 2
`endif
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         count,
  input  logic                     event_in,
  input  logic [1:0]               edge_sel,
  output logic                     cap_valid,
  input  logic                     cap_ready,
  output logic [WIDTH-1:0]         cap_data,
`ifdef COUNT_CAPTURE_EPOCH_EN
  output logic [EPOCH_W-1:0]       cap_epoch,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int ACW = $clog2(SYNC_STAGES + 2);
`ifdef COUNT_CAPTURE_EPOCH_EN
  localparam int ENTRY_W = EPOCH_W + WIDTH;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [ACW-1:0]         arm_cnt, arm_cnt_nxt;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q, prev;
  logic                   rise, fall, hit, capture;

  logic [ENTRY_W-1:0]     mem [DEPTH];
  logic [ENTRY_W-1:0]     wr_entry, head;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level;
  logic                   full, push, pop, ovf_set;

  // ---------------- edge detection ----------------
  assign sync_q  = sync_ff[SYNC_STAGES-1];
  assign rise    = sync_q & ~prev;
  assign fall    = ~sync_q & prev;
  assign hit     = (rise & edge_sel[0]) | (fall & edge_sel[1]);
  assign capture = (state == ACTIVE) & hit;

  // ---------------- FSM next state ----------------
  // ARM waits SYNC_STAGES+1 cycles so the synchroniser and prev flop reflect
  // the current line level before captures are allowed; a level that was
  // already present therefore never looks like an edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    arm_cnt_nxt = arm_cnt;
    case (state)
      IDLE: begin
        if (edge_sel != 2'b00) begin
          state_nxt   = ARM;
          arm_cnt_nxt = ACW'(SYNC_STAGES + 1);
        end
      end
      ARM: begin
        if (edge_sel == 2'b00)        state_nxt   = IDLE;
        else if (arm_cnt <= ACW'(1))  state_nxt   = ACTIVE;
        else                          arm_cnt_nxt = arm_cnt - 1'b1;
      end
      ACTIVE: begin
        if (edge_sel == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FIFO control ----------------
  assign cap_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = cap_valid & cap_ready;
  // A full FIFO still accepts a capture when the head leaves in the same cycle.
  assign push      = capture & (~full | pop);
  assign ovf_set   = capture & full & ~pop;
  assign head      = mem[rd_ptr];

`ifdef COUNT_CAPTURE_EPOCH_EN
  logic [WIDTH-1:0]   count_q;
  logic [EPOCH_W-1:0] epoch_q, epoch_nxt;

  // A drop in count marks a wrap or an upstream clear. A capture in that same
  // cycle stores the already-incremented epoch.
  assign epoch_nxt = epoch_q + EPOCH_W'(count_q > count);
  assign wr_entry  = {epoch_nxt, count};
  assign cap_epoch = cap_valid ? head[ENTRY_W-1:WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
      epoch_q <= '0;
    end else begin
      count_q <= count;
      epoch_q <= epoch_nxt;
    end
  end
`else
  assign wr_entry = count;
`endif

  // Stale storage is never exposed: the head reads as zero while empty.
  assign cap_data   = cap_valid ? head[WIDTH-1:0] : '0;
  assign fifo_level = level;

  // NOTE: storage has no reset; only the pointers and level define what is
  // valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // ---------------- control registers ----------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (clear) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      sync_ff  <= '0;
      prev     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      arm_cnt <= arm_cnt_nxt;
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], event_in};
      prev    <= sync_q;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (ovf_set)           overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_count_capture.sv
// ---------------------------------------------------------------------------
// tb_count_capture
//
// Self-checking bench for count_capture. A single process owns all inputs,
// including the upstream counter, and advances them on the falling edge.
// Each expected capture ({epoch, count}) is pushed to a queue when the event
// stimulus is applied; whenever the DUT head is popped the head is compared
// against the queue front. Status outputs are checked against values the
// bench derives from its own stimulus.
// ---------------------------------------------------------------------------
module tb_count_capture;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int EW = 4;

  logic                 clk = 1'b0;
  logic                 clear;
  logic [W-1:0]         count;
  logic                 event_in;
  logic [1:0]           edge_sel;
  logic                 cap_valid;
  logic                 cap_ready;
  logic [W-1:0]         cap_data;
`ifdef COUNT_CAPTURE_EPOCH_EN
  logic [EW-1:0]        cap_epoch;
`endif
  logic [$clog2(D):0]   fifo_level;
  logic                 overflow;
  logic                 overflow_clr;

  int                   n_checks = 0;
  int                   n_fail   = 0;
  logic [EW-1:0]        tb_epoch;
  logic [EW+W-1:0]      exp_q [$];

  count_capture #(
    .WIDTH       (W),
    .DEPTH       (D),
`ifdef COUNT_CAPTURE_EPOCH_EN
    .SYNC_STAGES (S),
    .EPOCH_W     (EW)
`else
    .SYNC_STAGES (S)
`endif
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .count        (count),
    .event_in     (event_in),
    .edge_sel     (edge_sel),
    .cap_valid    (cap_valid),
    .cap_ready    (cap_ready),
    .cap_data     (cap_data),
`ifdef COUNT_CAPTURE_EPOCH_EN
    .cap_epoch    (cap_epoch),
`endif
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected entry for an event line change applied now: the write lands
  // S cycles later, so the captured count is count+S, with the epoch bumped
  // if the counter wraps on the way there.
  function automatic logic [EW+W-1:0] exp_entry(input logic [W-1:0] c);
    logic [W:0]    s;
    logic [EW-1:0] ep;
    s  = {1'b0, c} + (W+1)'(S);
    ep = tb_epoch + EW'(s[W]);
    return {ep, s[W-1:0]};
  endfunction

  // One clock: score a pop if one is about to happen, then advance to the
  // next falling edge and step the upstream counter.
  task automatic cycle();
    logic [EW+W-1:0] e;
    if (cap_valid === 1'b1 && cap_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("pop_while_model_empty", 32'(cap_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("cap_data", 32'(cap_data), 32'(e[W-1:0]));
`ifdef COUNT_CAPTURE_EPOCH_EN
        check("cap_epoch", 32'(cap_epoch), 32'(e[EW+W-1:W]));
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
    count = count + 1'b1;
    if (count == '0) tb_epoch = tb_epoch + 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // One rising edge held for two cycles, then low for two.
  task automatic rise_pulse(input bit expect_kept);
    event_in = 1'b1;
    if (expect_kept) exp_q.push_back(exp_entry(count));
    cycles(2);
    event_in = 1'b0;
    cycles(2);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    cap_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    cap_ready = 1'b0;
    check("drain_model_empty", 32'(exp_q.size()), 32'(0));
    check("drain_level", 32'(fifo_level), 32'(0));
  endtask

  initial begin
    int n;
    clear        = 1'b1;
    count        = '0;
    tb_epoch     = '0;
    event_in     = 1'b0;
    edge_sel     = 2'b00;
    cap_ready    = 1'b0;
    overflow_clr = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    cycle();
    clear = 1'b0;
    check("rst_valid",    32'(cap_valid),  32'(0));
    check("rst_level",    32'(fifo_level), 32'(0));
    check("rst_overflow", 32'(overflow),   32'(0));
    check("rst_data",     32'(cap_data),   32'(0));

    // ---------------- rising capture and latency ----------------
    edge_sel = 2'b01;
    cycles(6);
    event_in = 1'b1;
    exp_q.push_back(exp_entry(count));
    cycle();
    check("lat_edge1_valid", 32'(cap_valid), 32'(0));
    cycle();
    check("lat_edge2_valid", 32'(cap_valid), 32'(0));
    cycle();
    check("lat_edge3_valid", 32'(cap_valid),  32'(1));
    check("lat_edge3_level", 32'(fifo_level), 32'(1));
    check("lat_edge3_data",  32'(cap_data),   32'(exp_q[0][W-1:0]));
    cap_ready = 1'b1;
    cycle();
    cap_ready = 1'b0;
    check("rise_pop_level", 32'(fifo_level), 32'(0));
    event_in = 1'b0;
    cycles(5);
    check("rise_ignores_fall", 32'(fifo_level), 32'(0));

    // ---------------- both edges ----------------
    edge_sel = 2'b11;
    event_in = 1'b1;
    exp_q.push_back(exp_entry(count));
    cycles(5);
    event_in = 1'b0;
    exp_q.push_back(exp_entry(count));
    cycles(4);
    check("both_level", 32'(fifo_level), 32'(2));
    check("both_head",  32'(cap_data),   32'(exp_q[0][W-1:0]));
    cap_ready = 1'b1;
    cycles(2);
    cap_ready = 1'b0;
    check("both_drain_level", 32'(fifo_level), 32'(0));
    check("both_drain_model", 32'(exp_q.size()), 32'(0));

    // ---------------- overflow ----------------
    edge_sel = 2'b01;
    for (int i = 0; i < 5; i++) rise_pulse(i < 4);
    cycles(2);
    check("ovf_level",  32'(fifo_level), 32'(4));
    check("ovf_flag",   32'(overflow),   32'(1));
    check("ovf_head",   32'(cap_data),   32'(exp_q[0][W-1:0]));
    cycle();
    check("ovf_head_hold", 32'(cap_data), 32'(exp_q[0][W-1:0]));
    overflow_clr = 1'b1;
    cycle();
    overflow_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'(0));

    // set and clear in the same cycle: set wins
    event_in = 1'b1;
    cycles(2);
    overflow_clr = 1'b1;
    cycle();
    overflow_clr = 1'b0;
    event_in     = 1'b0;
    check("ovf_set_wins",       32'(overflow),   32'(1));
    check("ovf_set_wins_level", 32'(fifo_level), 32'(4));
    overflow_clr = 1'b1;
    cycle();
    overflow_clr = 1'b0;
    check("ovf_cleared_again", 32'(overflow), 32'(0));
    cycles(2);

    // ---------------- full with simultaneous pop ----------------
    event_in = 1'b1;
    exp_q.push_back(exp_entry(count));
    cycles(2);
    cap_ready = 1'b1;
    cycle();
    cap_ready = 1'b0;
    event_in  = 1'b0;
    check("fwp_level",    32'(fifo_level), 32'(4));
    check("fwp_overflow", 32'(overflow),   32'(0));
    drain(10);

    // ---------------- no spurious capture ----------------
    edge_sel = 2'b00;
    cycles(2);
    event_in = 1'b1;
    cycles(4);
    edge_sel = 2'b01;
    cycles(8);
    check("spur_level_held", 32'(fifo_level), 32'(0));
    edge_sel = 2'b00;
    cycle();
    event_in = 1'b0;
    cycles(5);
    check("spur_disabled_fall", 32'(fifo_level), 32'(0));
    // rising edge that lands while still arming
    event_in = 1'b1;
    edge_sel = 2'b01;
    cycles(8);
    check("spur_arm_suppress", 32'(fifo_level), 32'(0));
    event_in = 1'b0;
    cycles(4);

    // ---------------- reset mid-operation ----------------
    for (int i = 0; i < 3; i++) rise_pulse(1'b1);
    cycles(2);
    check("mid_level_before", 32'(fifo_level), 32'(3));
    while (count == '1) cycle();
    clear    = 1'b1;
    event_in = 1'b1;
    exp_q.delete();
    tb_epoch = '0;
    cycle();
    clear = 1'b0;
    check("mid_clr_valid",    32'(cap_valid),  32'(0));
    check("mid_clr_level",    32'(fifo_level), 32'(0));
    check("mid_clr_overflow", 32'(overflow),   32'(0));
    check("mid_clr_data",     32'(cap_data),   32'(0));
    cycles(8);
    check("mid_clr_rearm", 32'(fifo_level), 32'(0));
    event_in = 1'b0;
    cycles(4);

`ifdef COUNT_CAPTURE_EPOCH_EN
    // ---------------- epoch after two wraps ----------------
    n = 0;
    while (!(tb_epoch == EW'(2) && count == W'(2)) && n < 200) begin
      cycle();
      n++;
    end
    check("epoch_wait_in_budget", 32'(n < 200), 32'(1));
    event_in = 1'b1;
    exp_q.push_back(exp_entry(count));
    cycles(3);
    event_in = 1'b0;
    check("epoch_two", 32'(cap_epoch), 32'(2));
    // capture coincident with a wrap takes the new epoch
    n = 0;
    while (count != W'(14) && n < 40) begin
      cycle();
      n++;
    end
    check("epoch_wrap_wait_in_budget", 32'(n < 40), 32'(1));
    event_in = 1'b1;
    exp_q.push_back(exp_entry(count));
    cycles(4);
    event_in = 1'b0;
    check("epoch_wrap_level", 32'(fifo_level), 32'(2));
    drain(10);
`endif

    check("sb_empty_at_end", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_capture.md
Name: count_capture

Overview:
- Input-capture stage downstream of the free-running up counter.
- Synchronises an asynchronous event line, detects the selected edge type and snapshots the counter's `count` value on each event.
- Queues snapshots in a small first-word-fall-through FIFO, drained by a valid/ready consumer.
- Flags lost captures in a sticky overflow bit.

Parameters:
- WIDTH, 4, width of `count` and `cap_data`; must match the upstream counter.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2, synchroniser flops on `event_in`; ≥2.

Ports:
- clk  in  1  sole clock; rising edge.
- clear  in  1  reset, synchronous, active-high.
- count  in  WIDTH  counter value from the upstream up counter, synchronous to clk.
- event_in  in  1  asynchronous event line.
- edge_sel  in  2  edge select: 00 disabled, 01 rising, 10 falling, 11 both.
- cap_valid  out  1  FIFO head valid.
- cap_ready  in  1  consumer accepts head.
- cap_data  out  WIDTH  FIFO head count value.
- fifo_level  out  $clog2(DEPTH)+1  entries held.
- overflow  out  1  sticky: a capture was dropped.
- overflow_clr  in  1  clears `overflow`.

Behaviour:
- **Reset** (`clear`=1 at a clk edge): FSM→IDLE; sync flops, `prev` flop, FIFO pointers and `overflow` all 0. `cap_valid`=0, `fifo_level`=0, `cap_data`=0. Reset mid-operation discards FIFO contents.
- **Synchroniser:** SYNC_STAGES flops; `sync_q` is the last stage. `prev` registers `sync_q` every cycle in all states.
- **Edge detect** (combinational): rise = `sync_q`&~`prev`; fall = ~`sync_q`&`prev`; `hit` = (rise&`edge_sel`[0]) | (fall&`edge_sel`[1]).
- **FSM:**
  - IDLE: no captures. Go to ARM when `edge_sel`≠00.
  - ARM: down-counter loaded with SYNC_STAGES+1 on entry; captures suppressed; go to ACTIVE when it expires. This primes `prev` so a level already present gives no spurious capture.
  - ACTIVE: capture on `hit`.
  - From ARM or ACTIVE, `edge_sel`=00 returns to IDLE on the next edge. Changing `edge_sel` between non-zero codes stays in ACTIVE and takes effect immediately.
- **Capture:** in ACTIVE with `hit`=1, the `count` present that cycle is written at the closing edge.
- **Latency:** the first clk edge sampling `event_in` high is edge 1. `hit` is true in the cycle after edge SYNC_STAGES. The write occurs at edge SYNC_STAGES+1, and `cap_valid` is high after that edge. There is no bypass; an empty FIFO never presents same-cycle data.
- **FIFO:** FWFT.
  - Pop when `cap_valid`&`cap_ready`.
  - Push and pop in the same cycle are both honoured, `fifo_level` unchanged, including when full.
  - Push when full without pop: capture dropped, contents unchanged, `overflow` set.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH. `fifo_level` is exact, 0..DEPTH.
- **Overflow:** set and `overflow_clr` in the same cycle → set wins. `overflow_clr` otherwise clears it at the next edge.
- **Counter wrap:** no special handling; `cap_data` is the raw count, wrap from 2^WIDTH−1 to 0 is consumer's concern.
- **Handshake:** `cap_data` holds stable while `cap_valid`=1 and `cap_ready`=0.

Optional Feature:
- Macro: COUNT_CAPTURE_EPOCH_EN.
- **Defined:**
  - Adds parameter EPOCH_W (default 4) and output `cap_epoch` [EPOCH_W-1:0].
  - An internal epoch counter increments, modulo 2^EPOCH_W, whenever the registered previous `count` is greater than the current `count`. This covers both natural wrap and upstream clear.
  - Each FIFO entry stores {epoch, count}, so `cap_epoch` accompanies `cap_data`.
  - A capture coincident with a wrap stores the post-increment epoch.
  - The epoch counter resets to 0.
- **Undefined:** no epoch logic, no `cap_epoch` port, FIFO entries are WIDTH bits.

Test Plan:
- **Rising capture:** defaults, `edge_sel`=01, wait ARM; raise `event_in` while `count` ramps 0..15 → one entry equal to `count` at edge 3 after first sampled high; `cap_valid` after edge 3; `fifo_level`=1.
- **Both edges:** `edge_sel`=11, pulse `event_in` high for 5 cycles → two entries whose values differ by 5 (mod 16); `cap_ready`=1 drains both in 2 cycles.
- **Overflow:** `cap_ready`=0, 5 rising edges, DEPTH=4 → `fifo_level`=4, `overflow`=1, entries are the first 4 captures. `overflow_clr` with no new push → `overflow`=0.
- **Full with pop:** full FIFO, `cap_ready`=1, simultaneous capture → `fifo_level` stays 4, `overflow` stays 0, new value at tail.
- **No spurious capture:** `event_in` held high, `edge_sel` 00→01 → no capture through ARM or after. Then `edge_sel`=00 mid-pulse and a falling edge → no capture.
- **Reset mid-operation:** 3 entries queued, `clear` for 1 cycle → `cap_valid`=0, `fifo_level`=0, `overflow`=0, FSM IDLE. With COUNT_CAPTURE_EPOCH_EN, a capture after two counter wraps reads `cap_epoch`=2.
